// File: rtl/bram_word_serializer_pkg.sv
// Shared types and constants for the BRAM word-to-pixel serializer.
package bram_word_serializer_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned RD_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Map the emission index to the physical byte lane of the word.
  function automatic logic [1:0] lane_sel(input logic [1:0] idx, input logic lsb_first);
    return lsb_first ? idx : 2'(2'd3 - idx);
  endfunction

endpackage

// File: rtl/bram_word_serializer_word_skid_buf.sv
// Two-slot word buffer: a current (draining) word plus one prefetched word.
module word_skid_buf
  import bram_word_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] cur_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [WORD_W-1:0] cur_q, cur_d, pf_q, pf_d;
  logic              cur_full_q, cur_full_d, pf_full_q, pf_full_d;

  // A pop frees the current slot in the same cycle a push may refill it.
  always_comb begin
    cur_d      = cur_q;
    pf_d       = pf_q;
    cur_full_d = cur_full_q;
    pf_full_d  = pf_full_q;
    if (pop_i) begin
      if (pf_full_q) begin
        cur_d = pf_q;
        if (push_i) pf_d = push_data_i;
        else        pf_full_d = 1'b0;
      end else if (push_i) begin
        cur_d = push_data_i;
      end else begin
        cur_full_d = 1'b0;
      end
    end else if (push_i) begin
      if (!cur_full_q) begin
        cur_d      = push_data_i;
        cur_full_d = 1'b1;
      end else begin
        pf_d      = push_data_i;
        pf_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      pf_q       <= '0;
      cur_full_q <= 1'b0;
      pf_full_q  <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      pf_q       <= pf_d;
      cur_full_q <= cur_full_d;
      pf_full_q  <= pf_full_d;
    end
  end

  assign cur_o   = cur_q;
  assign full_o  = cur_full_q & pf_full_q;
  assign empty_o = ~cur_full_q;

endmodule

// File: rtl/bram_word_serializer.sv
// Reads 32-bit words from a result BRAM and streams them out as bytes
// with a valid/ready handshake, lossless under back-pressure.
module bram_word_serializer
  import bram_word_serializer_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned NUM_WORDS = 512,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [WORD_W-1:0] bram_dout,
  output logic [BYTE_W-1:0] px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_last
);

  localparam int unsigned      CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(NUM_WORDS);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [1:0]              idx_q, idx_d;
  logic [RD_LATENCY-1:0]   inflight_q;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    inflight, rd_issue, xfer, pop;
  logic                    buf_full, buf_empty;
  logic [WORD_W-1:0]       cur_word;
  logic [1:0]              lane;

  assign inflight = inflight_q[RD_LATENCY-1];

  word_skid_buf u_buf (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (inflight),
    .push_data_i (bram_dout),
    .pop_i       (pop),
    .cur_o       (cur_word),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  // Next-state, counters and handshake decode.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    idx_d    = idx_q;
    // Issue only if a slot is guaranteed when the data lands, counting the read in flight.
    rd_issue = (state_q == ST_RUN) && (rd_cnt_q < WORD_CNT) &&
               !buf_full && !(inflight && !buf_empty);
    xfer     = !buf_empty && px_ready;
    pop      = xfer && (idx_q == 2'd3);

    if (rd_issue) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    if (xfer)     idx_d    = idx_q + 2'd1;
    if (pop)      wr_cnt_d = wr_cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          idx_d    = '0;
        end
      end
      ST_RUN:   if (rd_issue && (rd_cnt_q == LAST_WORD)) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && (wr_cnt_q == LAST_WORD))      state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      idx_q      <= '0;
      inflight_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      idx_q      <= idx_d;
      inflight_q <= RD_LATENCY'(rd_issue);
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign lane      = lane_sel(idx_q, LSB_FIRST);
  assign busy      = busy_q;
  assign done      = done_q;
  assign bram_en   = rd_issue;
  assign bram_addr = rd_cnt_q[ADDR_W-1:0];
  assign px_valid  = !buf_empty;
  assign px_data   = cur_word[{lane, 3'b000} +: BYTE_W];
  assign px_last   = px_valid && (idx_q == 2'd3) && (wr_cnt_q == LAST_WORD);

endmodule

// File: tb/tb_bram_word_serializer.sv
// Scoreboard bench: dut0 LSB-first with NUM_WORDS = 2**ADDR_W, dut1 MSB-first, 3 words.
module tb_bram_word_serializer;

  localparam int NW [2] = '{4, 3};
  localparam bit LF [2] = '{1'b1, 1'b0};

  logic        clk;
  logic        rst_n;
  logic        start     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        bram_en   [2];
  logic [1:0]  bram_addr [2];
  logic [31:0] bram_dout [2];
  logic [7:0]  px_data   [2];
  logic        px_valid  [2];
  logic        px_ready  [2];
  logic        px_last   [2];

  logic [31:0] mem [2][4];

  bram_word_serializer #(.ADDR_W(2), .NUM_WORDS(4), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .bram_en(bram_en[0]), .bram_addr(bram_addr[0]), .bram_dout(bram_dout[0]),
    .px_data(px_data[0]), .px_valid(px_valid[0]), .px_ready(px_ready[0]), .px_last(px_last[0]));

  bram_word_serializer #(.ADDR_W(2), .NUM_WORDS(3), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .bram_en(bram_en[1]), .bram_addr(bram_addr[1]), .bram_dout(bram_dout[1]),
    .px_data(px_data[1]), .px_valid(px_valid[1]), .px_ready(px_ready[1]), .px_last(px_last[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (bram_en[0]) bram_dout[0] <= mem[0][bram_addr[0]];
    if (bram_en[1]) bram_dout[1] <= mem[1][bram_addr[1]];
  end

  int       n_checks = 0;
  int       n_fail   = 0;
  logic [8:0] exp_q  [2][$];
  int       addr_q   [2][$];

  // Stimulus-side controls read by the monitor.
  int       mode      [2];
  bit       free_run  [2];
  int       cyc = 0;
  int       stall_from = 1 << 30;

  // Monitor-side reference state.
  int       occ       [2];
  int       lat       [2];
  int       byte_cnt  [2];
  int       xfer_total[2];
  bit       busy_exp  [2];
  bit       done_exp  [2];
  bit       idle_m    [2];
  bit       prev_stall[2];
  logic [8:0] prev_beat [2];

  function automatic void chk(input string name, input int i,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, i, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name, input int i, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s dut%0d: got 0x%0h with nothing expected at %0t", name, i, act, $time);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("reset_outputs", i,
            32'({busy[i], done[i], bram_en[i], px_valid[i], px_last[i], px_data[i], bram_addr[i]}), 32'd0);
        occ[i] = 0; lat[i] = 1000; byte_cnt[i] = 0;
        busy_exp[i] = 1'b0; done_exp[i] = 1'b0; idle_m[i] = 1'b1; prev_stall[i] = 1'b0;
      end else begin
        automatic bit fin = done_exp[i];
        if (lat[i] < 1000) lat[i]++;
        chk("busy", i, 32'(busy[i]), 32'(busy_exp[i]));
        chk("done", i, 32'(done[i]), 32'(done_exp[i]));
        done_exp[i] = 1'b0;

        if (lat[i] == 1) chk("lat_first_bram_en", i, 32'(bram_en[i]), 32'd1);
        if (lat[i] == 1 || lat[i] == 2) chk("lat_valid_early", i, 32'(px_valid[i]), 32'd0);
        if (lat[i] == 3) chk("lat_first_valid", i, 32'(px_valid[i]), 32'd1);

        if (prev_stall[i])
          chk("stall_hold", i, 32'({px_valid[i], px_last[i], px_data[i]}), 32'({1'b1, prev_beat[i]}));

        if (bram_en[i]) begin
          chk("slot_free_on_issue", i, 32'(occ[i] <= 1), 32'd1);
          if (addr_q[i].size() == 0) fail_now("extra_read", i, 32'(bram_addr[i]));
          else chk("bram_addr", i, 32'(bram_addr[i]), 32'(addr_q[i].pop_front()));
          occ[i]++;
        end

        if (px_valid[i] && px_ready[i]) begin
          if (exp_q[i].size() == 0) fail_now("extra_byte", i, 32'({px_last[i], px_data[i]}));
          else chk("byte_last", i, 32'({px_last[i], px_data[i]}), 32'(exp_q[i].pop_front()));
          byte_cnt[i]++;
          xfer_total[i]++;
          if (byte_cnt[i] % 4 == 0) occ[i]--;
          if (px_last[i]) begin
            done_exp[i] = 1'b1;
            busy_exp[i] = 1'b0;
            if (free_run[i]) chk("no_bubble", i, 32'(lat[i]), 32'(4 * NW[i] + 2));
          end
        end

        prev_stall[i] = px_valid[i] && !px_ready[i];
        prev_beat[i]  = {px_last[i], px_data[i]};

        if (start[i] && idle_m[i]) begin
          idle_m[i] = 1'b0; busy_exp[i] = 1'b1; lat[i] = 0; byte_cnt[i] = 0;
        end
        if (fin) idle_m[i] = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      case (mode[i])
        1:       px_ready[i] = (cyc % 3 == 0);
        2:       px_ready[i] = 1'($urandom_range(0, 1));
        3:       px_ready[i] = !(cyc >= stall_from && cyc < stall_from + 10);
        default: px_ready[i] = 1'b1;
      endcase
    end
  endtask

  // Push the whole expected frame, then pulse start.
  task automatic start_frame(input int i);
    for (int k = 0; k < NW[i]; k++) begin
      addr_q[i].push_back(k);
      for (int b = 0; b < 4; b++) begin
        automatic int lane = LF[i] ? b : 3 - b;
        automatic logic [7:0] by = 8'(mem[i][k] >> (8 * lane));
        exp_q[i].push_back({1'((k == NW[i] - 1) && (b == 3)), by});
      end
    end
    free_run[i] = (mode[i] == 0);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input bit start_on_done);
    int n = 0;
    while (!done[i]) begin
      step();
      n++;
      if (n > 400) begin
        $display("FAIL done_timeout dut%0d: no done after %0d cycles", i, n);
        $fatal(1, "timeout");
      end
    end
    if (start_on_done) start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  task automatic randomize_mem(input int i);
    for (int k = 0; k < 4; k++) mem[i][k] = $urandom;
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; px_ready[i] = 1'b1; mode[i] = 0; free_run[i] = 1'b0;
      xfer_total[i] = 0; lat[i] = 1000; idle_m[i] = 1'b1;
      randomize_mem(i);
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Free-run: bytes 0x00..0x0F back to back.
    for (int k = 0; k < 4; k++) mem[0][k] = 32'h0302_0100 + 32'(k) * 32'h0404_0404;
    start_frame(0);
    wait_done(0, 1'b0);
    step();

    // MSB-first ordering.
    randomize_mem(1);
    mem[1][0] = 32'hAABB_CCDD;
    start_frame(1);
    wait_done(1, 1'b0);
    step();

    // 1/3-duty back-pressure, plus a start while busy and one coincident with done.
    mode[0] = 1;
    randomize_mem(0);
    start_frame(0);
    repeat (8) step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_done(0, 1'b1);
    repeat (2) step();

    // Sink held off for 10 cycles in the middle of a word.
    mode[0] = 3;
    stall_from = cyc + 5;
    randomize_mem(0);
    start_frame(0);
    wait_done(0, 1'b0);
    step();

    // Async reset after 5 bytes, then replay from address 0.
    mode[0] = 0;
    randomize_mem(0);
    base = xfer_total[0];
    start_frame(0);
    for (int n = 0; xfer_total[0] < base + 5; n++) begin
      if (n > 100) begin
        $display("FAIL reset_wait dut0: only %0d bytes seen", xfer_total[0] - base);
        $fatal(1, "timeout");
      end
      step();
    end
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      addr_q[i].delete();
    end
    step();
    rst_n = 1'b1;
    repeat (2) step();
    start_frame(0);
    wait_done(0, 1'b0);
    step();

    // Random back-pressure frames on both instances.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) begin
        mode[i] = 2;
        randomize_mem(i);
        start_frame(i);
        wait_done(i, 1'b0);
        step();
      end
    end
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_word_serializer.md
Name: bram_word_serializer

Overview:
- Readout-side block for the image pipeline. Fetches 32-bit processed-pixel words from a result BRAM read port (1-cycle read latency) and emits them as an 8-bit pixel stream with a valid/ready handshake.
- This is the reverse of the input path, where an 8-bit pixel write port feeds a 32-bit read port.
- Sustains 1 byte/cycle when the sink is always ready, and holds data losslessly under back-pressure.

Parameters:
- ADDR_W, 9, BRAM word-address width.
- NUM_WORDS, 512, words per frame (1..2**ADDR_W).
- LSB_FIRST, 1, 1: byte[7:0] is emitted first; 0: byte[31:24] is emitted first.

Ports:
- clk  in  1  single clock for all logic and the BRAM read port.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  1-cycle pulse that begins a frame; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  1-cycle pulse the cycle after the last byte handshakes.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_W  BRAM read word address.
- bram_dout  in  32  BRAM read data, valid the cycle after bram_en=1.
- px_data  out  8  output pixel.
- px_valid  out  1  px_data is valid.
- px_ready  in  1  sink accepts; a transfer occurs when px_valid & px_ready.
- px_last  out  1  marks the final byte of the frame (qualified by px_valid).

Behaviour:
- Reset (reset=0, async): every output is 0; the FSM goes to IDLE; all counters and buffers are cleared. Reset mid-frame abandons the frame with no done pulse.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE -> RUN on start=1.
  - RUN -> DRAIN when the last read is issued.
  - DRAIN -> FIN when the last byte transfers.
  - FIN -> IDLE unconditionally. done=1 during FIN.
- Read issue:
  - The read counter rd_cnt runs 0..NUM_WORDS-1. bram_addr = rd_cnt.
  - bram_en=1 in any cycle where rd_cnt < NUM_WORDS and a buffer slot will be free when the data returns. The slot count is checked combinationally, including one in-flight read.
  - An in-flight flag marks that bram_dout is to be captured in the next cycle.
- Buffering:
  - Two 32-bit slots: the current word (shifting) and the prefetch word.
  - Returned data goes to the current word if it is empty, otherwise to the prefetch word.
  - A read is never issued if both slots would be occupied, so no data is ever dropped.
- Byte output:
  - px_valid=1 whenever the current word is occupied.
  - A 2-bit byte index selects the lane. With LSB_FIRST=1 lane = index; with 0, lane = 3 - index.
  - Each transfer increments the index.
  - On the transfer at index 3, the current word loads from prefetch in the same cycle if prefetch is occupied, or from the returning BRAM data if a read is in flight. Otherwise the current word becomes empty.
- Latency:
  - start -> first bram_en: 1 cycle.
  - start -> first px_valid: 3 cycles.
  - With px_ready held at 1 there are no bubbles: 4*NUM_WORDS consecutive transfers.
- Back-pressure: while px_valid=1 and px_ready=0, px_data, px_last and px_valid hold stable. px_valid never drops without a transfer.
- px_last = px_valid & (byte index=3) & (current word is word NUM_WORDS-1).
- start during busy: ignored, with no restart and no error.
- start in the same cycle as done: ignored. A new start is accepted in IDLE only.
- Width rules: rd_cnt and the output word counter are ADDR_W+1 bits wide, so NUM_WORDS = 2**ADDR_W terminates without wrap-around aliasing.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DRAIN/FIN), the byte-lane select function, and the BRAM read-latency constant (=1).
- One natural sub-module: word_skid_buf, the two-slot 32-bit buffer with push/pop/full/empty.
- The FSM, counters and byte mux stay in the top.

Test Plan:
- Free-run: NUM_WORDS=4, BRAM word k = 0x03020100 + k*0x04040404, px_ready=1 -> bytes 0x00..0x0F on 16 consecutive cycles. First px_valid 3 cycles after start. px_last only with 0x0F. done pulses 1 cycle after it.
- Back-pressure: px_ready toggled by a 1/3-duty pattern and also held low for 10 cycles mid-word -> identical byte sequence, no drops or duplicates. Outputs stable while stalled. bram_en never fires with both slots full.
- LSB_FIRST=0: word 0xAABBCCDD -> bytes AA, BB, CC, DD in order.
- Boundary: ADDR_W=2, NUM_WORDS=4 -> addresses 0,1,2,3 issued exactly once each. No wrap to 0. busy falls when done pulses.
- Reset mid-frame: reset=0 for 1 cycle after 5 bytes -> all outputs 0 immediately (async), no done. A new start replays the frame from address 0.
- start ignored: a start pulse while busy, and another coincident with done -> no restart. A following start in IDLE runs normally.
